// File: rtl/pmem_arb_pkg.sv
// pmem_arb_pkg
//   Shared types and constants for the physical-memory arbiter slice.
//   Items:
//     LINE_W       cacheline width in bits (matches the caches' s_line)
//     arb_state_t  arbiter FSM states: IDLE, GRANT_I, GRANT_D
package pmem_arb_pkg;

  localparam int LINE_W = 256;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } arb_state_t;

endpackage

// File: rtl/pmem_arbiter_if.sv
// pmem_arbiter_if
//   Bundles the I-cache, D-cache and cacheline-adapter pmem signals that meet
//   at the arbiter.
//   Modports:
//     slave   arbiter view: cache requests and adapter results in,
//             cache results and adapter requests out
//     master  environment view (caches + adapter), the mirror of slave
//   Signals:
//     i_pmem_read/i_pmem_address              I-cache line read request
//     i_pmem_rdata/i_pmem_resp                I-cache line data and done
//     d_pmem_read/d_pmem_write/d_pmem_address/d_pmem_wdata   D-cache request
//     d_pmem_rdata/d_pmem_resp                D-cache line data and done
//     ca_read/ca_write/ca_address/ca_wdata    request to cacheline adapter
//     ca_rdata/ca_resp                        result from cacheline adapter
interface pmem_arbiter_if
  import pmem_arb_pkg::*;
#(
  parameter int S_LINE = LINE_W
);

  logic              i_pmem_read;
  logic [31:0]       i_pmem_address;
  logic [S_LINE-1:0] i_pmem_rdata;
  logic              i_pmem_resp;

  logic              d_pmem_read;
  logic              d_pmem_write;
  logic [31:0]       d_pmem_address;
  logic [S_LINE-1:0] d_pmem_wdata;
  logic [S_LINE-1:0] d_pmem_rdata;
  logic              d_pmem_resp;

  logic              ca_read;
  logic              ca_write;
  logic [31:0]       ca_address;
  logic [S_LINE-1:0] ca_wdata;
  logic [S_LINE-1:0] ca_rdata;
  logic              ca_resp;

  modport slave (
    input  i_pmem_read, i_pmem_address,
    output i_pmem_rdata, i_pmem_resp,
    input  d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
    output d_pmem_rdata, d_pmem_resp,
    output ca_read, ca_write, ca_address, ca_wdata,
    input  ca_rdata, ca_resp
  );

  modport master (
    output i_pmem_read, i_pmem_address,
    input  i_pmem_rdata, i_pmem_resp,
    output d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
    input  d_pmem_rdata, d_pmem_resp,
    input  ca_read, ca_write, ca_address, ca_wdata,
    output ca_rdata, ca_resp
  );

endinterface

// File: rtl/pmem_arb_checker.sv
// pmem_arb_checker
//   Protocol checks for the arbiter's cache-side handshake. Ignored while
//   rst is high.
//   Ports:
//     clk, rst   system clock, synchronous active-high reset
//     i_read     I-cache read request
//     d_read     D-cache read request
//     d_write    D-cache write request
//     state      arbiter FSM state
module pmem_arb_checker
  import pmem_arb_pkg::*;
(
  input logic       clk,
  input logic       rst,
  input logic       i_read,
  input logic       d_read,
  input logic       d_write,
  input arb_state_t state
);

  // The D-cache must never ask for a read and a write in the same cycle.
  a_d_rw_excl: assert property (@(posedge clk) disable iff (rst) !(d_read && d_write))
    else $error("pmem_arb_checker: D-cache read and write asserted together");

  // A granted requester must keep its request up until the adapter responds.
  a_i_hold: assert property (@(posedge clk) disable iff (rst) (state == GRANT_I) |-> i_read)
    else $error("pmem_arb_checker: I-cache dropped its request during a grant");

  a_d_hold: assert property (@(posedge clk) disable iff (rst) (state == GRANT_D) |-> (d_read || d_write))
    else $error("pmem_arb_checker: D-cache dropped its request during a grant");

endmodule

// File: rtl/pmem_arb_stats.sv
// pmem_arb_stats
//   Grant statistics for the pmem arbiter. Present only when the build
//   defines PMEM_ARB_STATS_EN. All counters wrap and clear on rst.
//   Ports:
//     clk, rst        system clock, synchronous active-high reset
//     grant_i         pulse: an I-cache grant is issued this edge
//     grant_d         pulse: a D-cache grant is issued this edge
//     forced_i        pulse: the I grant was forced by the starvation limit
//     i_grant_count   I-cache grants issued
//     d_grant_count   D-cache grants issued
//     starve_events   forced I-cache grants
`ifdef PMEM_ARB_STATS_EN
module pmem_arb_stats (
  input  logic        clk,
  input  logic        rst,
  input  logic        grant_i,
  input  logic        grant_d,
  input  logic        forced_i,
  output logic [31:0] i_grant_count,
  output logic [31:0] d_grant_count,
  output logic [31:0] starve_events
);

  // Count I grants.
  always_ff @(posedge clk) begin
    if (rst) begin
      i_grant_count <= 32'd0;
    end else if (grant_i) begin
      i_grant_count <= i_grant_count + 32'd1;
    end
  end

  // Count D grants.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_grant_count <= 32'd0;
    end else if (grant_d) begin
      d_grant_count <= d_grant_count + 32'd1;
    end
  end

  // Count I grants that overrode a pending D request.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_events <= 32'd0;
    end else if (forced_i) begin
      starve_events <= starve_events + 32'd1;
    end
  end

endmodule
`endif

// File: rtl/pmem_arbiter.sv
// pmem_arbiter
//   Shares one cacheline adapter between the I-cache (read only) and the
//   D-cache (read/write). The D side has fixed priority; a starvation
//   counter forces an I grant after STARVE_LIMIT consecutive D grants that
//   were issued while I was waiting. Each grant costs one arbitration cycle
//   in IDLE, and a grant lasts until the adapter's ca_resp.
//   Parameters:
//     S_LINE        cacheline width in bits
//     STARVE_LIMIT  D grants tolerated while I waits (>= 1)
//   Ports:
//     clk, rst      system clock, synchronous active-high reset
//     bus           pmem_arbiter_if.slave: both caches' pmem_* and the ca_* port
//   Optional build macro:
//     PMEM_ARB_STATS_EN  adds i_grant_count, d_grant_count, starve_events
//                        (wrapping 32-bit counters, cleared by rst)
module pmem_arbiter
  import pmem_arb_pkg::*;
#(
  parameter int S_LINE       = LINE_W,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  pmem_arbiter_if.slave bus
`ifdef PMEM_ARB_STATS_EN
  ,
  output logic [31:0]   i_grant_count,
  output logic [31:0]   d_grant_count,
  output logic [31:0]   starve_events
`endif
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

  arb_state_t       state_r;
  arb_state_t       state_next_s;
  logic [CNT_W-1:0] starve_cnt_r;
  logic [CNT_W-1:0] starve_cnt_next_s;
  logic             i_req_s;
  logic             d_req_s;
  logic             starve_hit_s;

  assign i_req_s = bus.i_pmem_read;
  assign d_req_s = bus.d_pmem_read | bus.d_pmem_write;
  // I has waited through STARVE_LIMIT D grants and must go next.
  assign starve_hit_s = i_req_s && (starve_cnt_r == LIMIT_C);

  // Next-state and starvation-count decision.
  always_comb begin
    state_next_s      = state_r;
    starve_cnt_next_s = starve_cnt_r;
    case (state_r)
      IDLE: begin
        if (d_req_s && !starve_hit_s) begin
          state_next_s = GRANT_D;
          if (i_req_s) begin
            // starve_hit_s is clear here, so the count is below the limit
            // and the increment cannot pass it.
            starve_cnt_next_s = starve_cnt_r + CNT_W'(1'b1);
          end else begin
            starve_cnt_next_s = {CNT_W{1'b0}};
          end
        end else if (i_req_s) begin
          state_next_s      = GRANT_I;
          starve_cnt_next_s = {CNT_W{1'b0}};
        end else begin
          state_next_s      = IDLE;
          starve_cnt_next_s = {CNT_W{1'b0}};
        end
      end
      GRANT_I: begin
        if (bus.ca_resp) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = GRANT_I;
        end
      end
      GRANT_D: begin
        if (bus.ca_resp) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = GRANT_D;
        end
      end
      default: begin
        state_next_s      = IDLE;
        starve_cnt_next_s = {CNT_W{1'b0}};
      end
    endcase
  end

  // State and starvation-count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      starve_cnt_r <= {CNT_W{1'b0}};
    end else begin
      state_r      <= state_next_s;
      starve_cnt_r <= starve_cnt_next_s;
    end
  end

  // Route the granted requester onto the adapter; ca_resp only reaches the
  // owner of the current grant, so a stray response in IDLE goes nowhere.
  always_comb begin
    bus.ca_read     = 1'b0;
    bus.ca_write    = 1'b0;
    bus.ca_address  = 32'h0000_0000;
    bus.ca_wdata    = {S_LINE{1'b0}};
    bus.i_pmem_resp = 1'b0;
    bus.d_pmem_resp = 1'b0;
    case (state_r)
      IDLE: begin
        bus.ca_read = 1'b0;
      end
      GRANT_I: begin
        bus.ca_read     = bus.i_pmem_read;
        bus.ca_address  = bus.i_pmem_address;
        bus.i_pmem_resp = bus.ca_resp;
      end
      GRANT_D: begin
        bus.ca_read     = bus.d_pmem_read;
        bus.ca_write    = bus.d_pmem_write;
        bus.ca_address  = bus.d_pmem_address;
        bus.ca_wdata    = bus.d_pmem_wdata;
        bus.d_pmem_resp = bus.ca_resp;
      end
      default: begin
        bus.ca_read = 1'b0;
      end
    endcase
  end

  // Line data goes to both caches; only the owner sees a resp.
  assign bus.i_pmem_rdata = bus.ca_rdata;
  assign bus.d_pmem_rdata = bus.ca_rdata;

  pmem_arb_checker u_checker (
    .clk     (clk),
    .rst     (rst),
    .i_read  (bus.i_pmem_read),
    .d_read  (bus.d_pmem_read),
    .d_write (bus.d_pmem_write),
    .state   (state_r)
  );

`ifdef PMEM_ARB_STATS_EN
  logic grant_i_s;
  logic grant_d_s;
  logic forced_i_s;

  assign grant_i_s  = (state_r == IDLE) && (state_next_s == GRANT_I);
  assign grant_d_s  = (state_r == IDLE) && (state_next_s == GRANT_D);
  // An I grant is forced when D was also asking in that arbitration cycle.
  assign forced_i_s = grant_i_s && d_req_s;

  pmem_arb_stats u_stats (
    .clk           (clk),
    .rst           (rst),
    .grant_i       (grant_i_s),
    .grant_d       (grant_d_s),
    .forced_i      (forced_i_s),
    .i_grant_count (i_grant_count),
    .d_grant_count (d_grant_count),
    .starve_events (starve_events)
  );
`endif

endmodule

// File: tb/tb_pmem_arbiter.sv
// tb_pmem_arbiter
//   Directed scenarios followed by a randomized phase. The bench plays both
//   caches and the cacheline adapter; a reference model tracks which cache
//   owns the adapter and the starvation count, and predicts every output
//   each cycle.
module tb_pmem_arbiter;
  import pmem_arb_pkg::*;

  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pmem_arbiter_if bus ();

`ifdef PMEM_ARB_STATS_EN
  logic [31:0] i_gc;
  logic [31:0] d_gc;
  logic [31:0] sev;
`endif

  pmem_arbiter #(.S_LINE(LINE_W), .STARVE_LIMIT(LIMIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef PMEM_ARB_STATS_EN
    ,
    .i_grant_count (i_gc),
    .d_grant_count (d_gc),
    .starve_events (sev)
`endif
  );

  int tests = 0;
  int fails = 0;

  // reference model: owner 0 = none, 1 = I-cache, 2 = D-cache
  int owner_m  = 0;
  int starve_m = 0;
  int lat_m    = 0;
  int i_gnt_m  = 0;
  int d_gnt_m  = 0;
  int sev_m    = 0;

  // cache / adapter agents
  bit           i_pend = 1'b0;
  bit           d_pend = 1'b0;
  bit           d_wr   = 1'b0;
  logic [31:0]  i_addr = 32'h0;
  logic [31:0]  d_addr = 32'h0;
  logic [255:0] d_wd   = 256'h0;
  int i_rate = 0, d_rate = 0, lat_lo = 1, lat_hi = 1, spur_rate = 0;
  bit rst_v = 1'b1;
  int log_q[$];  // responses seen from the DUT, 1 = I, 2 = D

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] rnd_line();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic step();
    logic         ca_resp_v;
    logic [255:0] rd_v;
    logic         e_rd, e_wr, e_ir, e_dr;
    logic [31:0]  e_addr;
    logic [255:0] e_wd;
    int           r;
    @(negedge clk);
    r = $urandom_range(99);
    if (!i_pend && r < i_rate) begin
      i_pend = 1'b1;
      i_addr = $urandom & 32'hFFFF_FFE0;
    end
    r = $urandom_range(99);
    if (!d_pend && r < d_rate) begin
      d_pend = 1'b1;
      d_wr   = 1'($urandom_range(1));
      d_addr = $urandom & 32'hFFFF_FFE0;
      d_wd   = rnd_line();
    end
    if (owner_m != 0) begin
      if (lat_m == 0) ca_resp_v = 1'b1;
      else begin
        ca_resp_v = 1'b0;
        lat_m--;
      end
    end else begin
      r = $urandom_range(99);
      ca_resp_v = (r < spur_rate);
    end
    rd_v = rnd_line();
    rst                = rst_v;
    bus.i_pmem_read    = i_pend;
    bus.i_pmem_address = i_addr;
    bus.d_pmem_read    = d_pend && !d_wr;
    bus.d_pmem_write   = d_pend && d_wr;
    bus.d_pmem_address = d_addr;
    bus.d_pmem_wdata   = d_wd;
    bus.ca_rdata       = rd_v;
    bus.ca_resp        = ca_resp_v;
    #1;
    e_rd = 1'b0; e_wr = 1'b0; e_ir = 1'b0; e_dr = 1'b0; e_addr = 32'h0; e_wd = 256'h0;
    if (owner_m == 1) begin
      e_rd = i_pend; e_addr = i_addr; e_ir = ca_resp_v;
    end else if (owner_m == 2) begin
      e_rd = d_pend && !d_wr; e_wr = d_pend && d_wr; e_addr = d_addr; e_wd = d_wd; e_dr = ca_resp_v;
    end
    chk("ca_read", bus.ca_read, e_rd);
    chk("ca_write", bus.ca_write, e_wr);
    chk("ca_address", bus.ca_address, e_addr);
    chk("ca_wdata", bus.ca_wdata, e_wd);
    chk("i_pmem_resp", bus.i_pmem_resp, e_ir);
    chk("d_pmem_resp", bus.d_pmem_resp, e_dr);
    chk("i_pmem_rdata", bus.i_pmem_rdata, rd_v);
    chk("d_pmem_rdata", bus.d_pmem_rdata, rd_v);
`ifdef PMEM_ARB_STATS_EN
    chk("i_grant_count", i_gc, 256'(i_gnt_m));
    chk("d_grant_count", d_gc, 256'(d_gnt_m));
    chk("starve_events", sev, 256'(sev_m));
`endif
    if (bus.i_pmem_resp === 1'b1) log_q.push_back(1);
    if (bus.d_pmem_resp === 1'b1) log_q.push_back(2);
    // advance the model across the coming clock edge
    if (rst_v) begin
      owner_m = 0; starve_m = 0; lat_m = 0; i_gnt_m = 0; d_gnt_m = 0; sev_m = 0;
    end else if (owner_m == 0) begin
      if (d_pend && !(i_pend && starve_m == LIMIT)) begin
        owner_m = 2;
        d_gnt_m++;
        starve_m = i_pend ? ((starve_m < LIMIT) ? starve_m + 1 : LIMIT) : 0;
        lat_m = $urandom_range(lat_hi, lat_lo);
      end else if (i_pend) begin
        owner_m = 1;
        i_gnt_m++;
        if (d_pend) sev_m++;
        starve_m = 0;
        lat_m = $urandom_range(lat_hi, lat_lo);
      end else begin
        starve_m = 0;
      end
    end else if (ca_resp_v) begin
      if (owner_m == 1) i_pend = 1'b0;
      else d_pend = 1'b0;
      owner_m = 0;
    end
  endtask

  task automatic run_quiet(input string tag, input int budget);
    int n = 0;
    while ((owner_m != 0 || i_pend || d_pend) && n < budget) begin
      step();
      n++;
    end
    chk({"timeout_", tag}, 256'(owner_m != 0 || i_pend || d_pend), 256'd0);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    bus.i_pmem_read = 1'b0; bus.i_pmem_address = 32'h0;
    bus.d_pmem_read = 1'b0; bus.d_pmem_write = 1'b0;
    bus.d_pmem_address = 32'h0; bus.d_pmem_wdata = 256'h0;
    bus.ca_rdata = 256'h0; bus.ca_resp = 1'b0;

    // reset held two cycles with both caches requesting
    rst_v = 1'b1; i_pend = 1'b1; i_addr = 32'h0000_2000;
    d_pend = 1'b1; d_wr = 1'b0; d_addr = 32'h0000_3000;
    lat_lo = 2; lat_hi = 2;
    step(); step();
    chk("rst_ca_read", bus.ca_read, 1'b0);
    chk("rst_d_resp", bus.d_pmem_resp, 1'b0);
    rst_v = 1'b0;
    step();
    chk("post_rst_idle", bus.ca_read, 1'b0);
    step();
    chk("first_grant_d", bus.ca_address, 32'h0000_3000);
    run_quiet("reset", 100);

    // lone I read, adapter answers after 5 cycles
    log_q.delete();
    i_pend = 1'b1; i_addr = 32'h0000_1040; lat_lo = 5; lat_hi = 5;
    step();
    step();
    chk("lone_i_read", bus.ca_read, 1'b1);
    chk("lone_i_addr", bus.ca_address, 32'h0000_1040);
    run_quiet("lone_i", 100);
    chk("lone_i_nresp", 256'(log_q.size()), 256'd1);
    if (log_q.size() > 0) chk("lone_i_who", 256'(log_q[0]), 256'd1);

    // simultaneous I read and D write: D first, one idle cycle, then I
    log_q.delete();
    i_pend = 1'b1; i_addr = 32'h0000_4000;
    d_pend = 1'b1; d_wr = 1'b1; d_addr = 32'h8000_0020; d_wd = {32{8'hA5}};
    lat_lo = 3; lat_hi = 3;
    step();
    step();
    chk("simul_d_write", bus.ca_write, 1'b1);
    chk("simul_d_addr", bus.ca_address, 32'h8000_0020);
    chk("simul_d_wdata", bus.ca_wdata, {32{8'hA5}});
    n = 0;
    while (d_pend && n < 50) begin step(); n++; end
    chk("simul_d_done", 256'(d_pend), 256'd0);
    step();
    chk("simul_idle_rd", bus.ca_read, 1'b0);
    chk("simul_idle_wr", bus.ca_write, 1'b0);
    step();
    chk("simul_i_read", bus.ca_read, 1'b1);
    chk("simul_i_addr", bus.ca_address, 32'h0000_4000);
    run_quiet("simul", 100);

    // starvation: continuous requests from both sides
    rst_v = 1'b1; step(); rst_v = 1'b0;
    log_q.delete();
    i_rate = 100; d_rate = 100; lat_lo = 0; lat_hi = 3;
    n = 0;
    while (log_q.size() < 5 && n < 200) begin step(); n++; end
    chk("starve_first5", 256'(log_q.size()), 256'd5);
`ifdef PMEM_ARB_STATS_EN
    chk("stats_d4", d_gc, 32'd4);
    chk("stats_i1", i_gc, 32'd1);
    chk("stats_sev1", sev, 32'd1);
`endif
    n = 0;
    while (log_q.size() < 10 && n < 200) begin step(); n++; end
    if (log_q.size() >= 10) begin
      for (int k = 0; k < 10; k++) chk($sformatf("starve_seq%0d", k), 256'(log_q[k]), (k == 4 || k == 9) ? 256'd1 : 256'd2);
    end else begin
      chk("starve_seq_len", 256'(log_q.size()), 256'd10);
    end
    i_rate = 0; d_rate = 0;
    run_quiet("starve", 100);

    // reset in the middle of a D grant
    log_q.delete();
    d_pend = 1'b1; d_wr = 1'b1; d_addr = 32'h0000_7700; d_wd = rnd_line();
    lat_lo = 20; lat_hi = 20;
    step(); step(); step();
    chk("mid_grant_wr", bus.ca_write, 1'b1);
    rst_v = 1'b1; step(); rst_v = 1'b0;
    d_pend = 1'b0;
    step();
    chk("mid_rst_wr", bus.ca_write, 1'b0);
    chk("mid_rst_addr", bus.ca_address, 32'h0);
    step();
    chk("mid_rst_nresp", 256'(log_q.size()), 256'd0);

    // randomized traffic with stray adapter responses while idle
    i_rate = 30; d_rate = 30; lat_lo = 0; lat_hi = 6; spur_rate = 20;
    for (int c = 0; c < 3000; c++) step();
    i_rate = 0; d_rate = 0;
    run_quiet("random", 200);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
